// File: rtl/circle_ring_sequencer.sv
// rtl/circle_ring_sequencer.sv - steps a half-circle around the outer ring of a 7-segment bank
module circle_ring_sequencer #(
    parameter int N_DIGITS = 6,
    parameter int TICK_DIV = 12_500_000
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            run_i,
    input  logic                            dir_i,
    input  logic                            clear_i,
    output logic [N_DIGITS-1:0]             en_o,
    output logic [N_DIGITS-1:0]             row_o,
    output logic [$clog2(2*N_DIGITS)-1:0]   pos_o,
    output logic                            step_o,
    output logic                            wrap_o
);

    localparam int RING = 2 * N_DIGITS;
    localparam int PW   = $clog2(RING);
    localparam int PSW  = $clog2(TICK_DIV);

    localparam logic [PW-1:0]  POS_LAST   = PW'(RING - 1);
    localparam logic [PSW-1:0] PRESC_LAST = PSW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                state_q, state_nxt;
    logic [PSW-1:0]        presc_q, presc_nxt;
    logic [PW-1:0]         pos_nxt;
    logic                  step_nxt, wrap_nxt;
    logic [N_DIGITS-1:0]   en_nxt, row_nxt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            presc_q <= '0;
            pos_o   <= '0;
            step_o  <= 1'b0;
            wrap_o  <= 1'b0;
            en_o    <= '0;
            row_o   <= '0;
        end else begin
            state_q <= state_nxt;
            presc_q <= presc_nxt;
            pos_o   <= pos_nxt;
            step_o  <= step_nxt;
            wrap_o  <= wrap_nxt;
            en_o    <= en_nxt;
            row_o   <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        presc_nxt = presc_q;
        pos_nxt   = pos_o;
        step_nxt  = 1'b0;
        wrap_nxt  = 1'b0;

        if (clear_i) begin
            state_nxt = ST_OFF;
            presc_nxt = '0;
            pos_nxt   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    if (run_i) begin
                        state_nxt = ST_RUN;
                        presc_nxt = '0;
                    end
                end
                ST_RUN: begin
                    // Dropping run wins over a terminal count: freeze without stepping.
                    if (!run_i) begin
                        state_nxt = ST_HOLD;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_nxt = '0;
                        step_nxt  = 1'b1;
                        if (dir_i) begin
                            if (pos_o == '0) begin
                                pos_nxt  = POS_LAST;
                                wrap_nxt = 1'b1;
                            end else begin
                                pos_nxt = pos_o - PW'(1);
                            end
                        end else begin
                            if (pos_o == POS_LAST) begin
                                pos_nxt  = '0;
                                wrap_nxt = 1'b1;
                            end else begin
                                pos_nxt = pos_o + PW'(1);
                            end
                        end
                    end else begin
                        presc_nxt = presc_q + PSW'(1);
                    end
                end
                ST_HOLD: begin
                    if (run_i) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    presc_nxt = '0;
                    pos_nxt   = '0;
                end
            endcase
        end
    end

    // Top edge runs HEX5->HEX0 with the upper circle, bottom edge HEX0->HEX5 with the lower one.
    always_comb begin
        int p;
        logic lit;
        p       = int'(pos_nxt);
        lit     = (state_nxt != ST_OFF);
        en_nxt  = '0;
        row_nxt = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (lit && (p < N_DIGITS) && (k == N_DIGITS - 1 - p)) begin
                en_nxt[k]  = 1'b1;
                row_nxt[k] = 1'b1;
            end else if (lit && (p >= N_DIGITS) && (k == p - N_DIGITS)) begin
                en_nxt[k] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_circle_ring_sequencer.sv
// tb/tb_circle_ring_sequencer.sv - directed self-checking bench for circle_ring_sequencer
module tb_circle_ring_sequencer;

    logic       clk;
    logic       rst_ni;
    logic       run_i;
    logic       dir_i;
    logic       clear_i;
    logic [5:0] en_o;
    logic [5:0] row_o;
    logic [3:0] pos_o;
    logic       step_o;
    logic       wrap_o;

    int n_assert = 0;
    int n_fail   = 0;
    int wraps    = 0;

    logic [5:0] en_tab  [12];
    logic [5:0] row_tab [12];

    circle_ring_sequencer #(
        .N_DIGITS(6),
        .TICK_DIV(4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .run_i  (run_i),
        .dir_i  (dir_i),
        .clear_i(clear_i),
        .en_o   (en_o),
        .row_o  (row_o),
        .pos_o  (pos_o),
        .step_o (step_o),
        .wrap_o (wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int pos, input logic st, input logic wr);
        chk({tag, "_pos"},  pos_o,  pos);
        chk({tag, "_en"},   en_o,   en_tab[pos]);
        chk({tag, "_row"},  row_o,  row_tab[pos]);
        chk({tag, "_step"}, step_o, st);
        chk({tag, "_wrap"}, wrap_o, wr);
    endtask

    initial begin
        en_tab  = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001,
                    6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
        row_tab = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001,
                    6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};

        rst_ni = 1'b0; run_i = 1'b0; dir_i = 1'b0; clear_i = 1'b0;
        tick(2);
        chk("rst_en", en_o, 6'b0);
        chk("rst_row", row_o, 6'b0);
        chk("rst_pos", pos_o, 0);
        chk("rst_step", step_o, 0);
        chk("rst_wrap", wrap_o, 0);

        rst_ni = 1'b1; run_i = 1'b1;
        tick(1);
        chk_all("start", 0, 1'b0, 1'b0);

        for (int s = 1; s <= 12; s++) begin
            for (int c = 0; c < 3; c++) begin
                tick(1);
                chk("cw_idle_step", step_o, 0);
                chk("cw_idle_wrap", wrap_o, 0);
            end
            tick(1);
            chk_all("cw", s % 12, 1'b1, s == 12);
            if (wrap_o) wraps++;
        end
        chk("cw_wrap_count", wraps, 1);

        dir_i = 1'b1;
        tick(3);
        chk("ccw_idle_step", step_o, 0);
        tick(1);
        chk_all("ccw_wrap", 11, 1'b1, 1'b1);

        dir_i = 1'b0;
        tick(2);
        chk("tog_pos_hold", pos_o, 11);
        dir_i = 1'b1;
        tick(2);
        chk_all("tog_ccw", 10, 1'b1, 1'b0);

        dir_i = 1'b1;
        tick(2);
        dir_i = 1'b0;
        tick(2);
        chk_all("tog_cw", 11, 1'b1, 1'b0);

        tick(2);
        run_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk("hold_step", step_o, 0);
            chk("hold_pos", pos_o, 11);
            chk("hold_en", en_o, 6'b100000);
        end
        run_i = 1'b1;
        tick(1);
        chk("resume1_step", step_o, 0);
        tick(1);
        chk("resume2_step", step_o, 0);
        tick(1);
        chk_all("resume_step", 0, 1'b1, 1'b1);

        tick(28);
        chk_all("pre_clear", 7, 1'b1, 1'b0);
        clear_i = 1'b1;
        tick(1);
        chk("clr_en", en_o, 6'b0);
        chk("clr_row", row_o, 6'b0);
        chk("clr_pos", pos_o, 0);
        chk("clr_step", step_o, 0);
        tick(2);
        chk("clr_hold_en", en_o, 6'b0);
        clear_i = 1'b0;
        tick(1);
        chk_all("post_clear", 0, 1'b0, 1'b0);
        tick(3);
        chk("post_clear_idle", step_o, 0);
        tick(1);
        chk_all("post_clear_step", 1, 1'b1, 1'b0);

        tick(3);
        rst_ni = 1'b0;
        tick(1);
        chk("mid_rst_en", en_o, 6'b0);
        chk("mid_rst_row", row_o, 6'b0);
        chk("mid_rst_pos", pos_o, 0);
        chk("mid_rst_step", step_o, 0);
        chk("mid_rst_wrap", wrap_o, 0);
        rst_ni = 1'b1; run_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            chk("off_en", en_o, 6'b0);
            chk("off_step", step_o, 0);
        end
        chk("off_pos", pos_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
